// File: rtl/multu_sequencer_pkg.sv
// Shared ALU definitions for the unsigned multiply sequencer:
// funct codes, multiplier command codes, FSM states and iteration count.
package multu_sequencer_pkg;

  // Number of shift-add iterations the multiplier needs for a 32x32 product.
  localparam int ITER = 32;

  // MIPS funct field values seen by the sequencer.
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  // Command codes on the multiplier Signal input.
  localparam logic [5:0] SIG_MUL = 6'b011001;
  localparam logic [5:0] SIG_OUT = 6'b111111;
  localparam logic [5:0] SIG_NOP = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_RUN     = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

endpackage

// File: rtl/multu_sequencer.sv
// Control stage in front of the shift-add multiplier: accepts MULTU,
// clears the accumulator, issues ITER MUL commands with stable operands,
// issues OUT, captures the 64-bit product into HI/LO and serves MFHI/MFLO.
module multu_sequencer #(
  parameter int ITER = multu_sequencer_pkg::ITER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [63:0] product,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic [5:0]  mul_signal,
  output logic        mul_clr,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);
  import multu_sequencer_pkg::*;

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [31:0]   a_q,     a_d;
  logic [31:0]   b_q,     b_d;
  logic [31:0]   hi_q,    hi_d;
  logic [31:0]   lo_q,    lo_d;
  logic          done_q,  done_d;
  logic          clr_st;
  logic [5:0]    sig;

  // Next-state, counter, operand latch and HI/LO capture decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    sig     = SIG_NOP;
    clr_st  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Operands only move on an accepted MULTU; other requests are dropped.
        if (start && funct == FUNCT_MULTU) begin
          a_d     = op_a;
          b_d     = op_b;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        clr_st  = 1'b1;
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        sig   = SIG_MUL;
        cnt_d = cnt_q + 1'b1;
        // Terminal compare on ITER-1 gives exactly ITER cycles in RUN.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        sig     = SIG_OUT;
        hi_d    = product[63:32];
        lo_d    = product[31:0];
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight multiply.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Multiplier accumulator is held clear during reset as well as in CLEAR.
  assign mul_clr    = ~reset | clr_st;
  assign mul_signal = sig;
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

  // Zero-latency read port so the new HI/LO are visible alongside done.
  always_comb begin
    rd_data = '0;
    if (funct == FUNCT_MFHI)      rd_data = hi_q;
    else if (funct == FUNCT_MFLO) rd_data = lo_q;
  end

endmodule

// File: tb/tb_multu_sequencer.sv
// Directed bench for multu_sequencer with a bit-serial shift-add multiplier model.
module tb_multu_sequencer;
  import multu_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] op_a, op_b;
  logic [63:0] product;
  logic [31:0] mul_a, mul_b;
  logic [5:0]  mul_signal;
  logic        mul_clr, busy, done;
  logic [31:0] hi, lo, rd_data;

  int n_chk  = 0;
  int n_pass = 0;

  multu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .op_a(op_a), .op_b(op_b), .product(product),
    .mul_a(mul_a), .mul_b(mul_b), .mul_signal(mul_signal), .mul_clr(mul_clr),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Multiplier model: one partial product per MUL command, cleared by mul_clr.
  logic [63:0] m_acc;
  int          m_i;
  always @(posedge clk) begin
    if (mul_clr) begin
      m_acc <= 64'd0;
      m_i   <= 0;
    end else if (mul_signal == SIG_MUL) begin
      if (m_i < 32 && mul_b[m_i[4:0]])
        m_acc <= m_acc + ({32'd0, mul_a} << m_i);
      m_i <= m_i + 1;
    end
  end
  assign product = m_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue a MULTU and step negedges until done (bounded). Optionally inject a
  // 7x9 start at cycle inj, or assert reset at cycle rst_at and return.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          input int inj, input int rst_at,
                          output int cyc, output int muls);
    start = 1'b1; funct = FUNCT_MULTU; op_a = a; op_b = b;
    cyc = 0; muls = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (mul_signal == SIG_MUL) muls++;
      start = 1'b0; funct = FUNCT_MFLO;
      if (cyc == inj) begin
        start = 1'b1; funct = FUNCT_MULTU; op_a = 32'd7; op_b = 32'd9;
      end
      if (cyc == rst_at) begin
        reset = 1'b0;
        return;
      end
    end while (!done && cyc < 100);
  endtask

  initial begin
    int cyc, muls, n_busy, n_sig, n_done;
    reset = 1'b0; start = 1'b0; funct = 6'd0; op_a = 32'd0; op_b = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_sig", mul_signal, SIG_NOP);
    chk("rst_clr", mul_clr, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_clr", mul_clr, 0);

    // 3 x 5: done 34 cycles after the accepting edge, 32 MUL cycles.
    run_mult(32'd3, 32'd5, -1, -1, cyc, muls);
    chk("t1_latency", cyc - 1, 34);
    chk("t1_muls", muls, 32);
    chk("t1_done", done, 1);
    chk("t1_hi", hi, 0);
    chk("t1_lo", lo, 15);
    chk("t1_rd_lo_at_done", rd_data, 15);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_idle", busy, 0);

    // Max operands and the read port.
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, cyc, muls);
    chk("t2_hi", hi, 32'hFFFF_FFFE);
    chk("t2_lo", lo, 32'h0000_0001);
    @(negedge clk);
    funct = FUNCT_MFHI; #1;
    chk("t2_rd_hi", rd_data, 32'hFFFF_FFFE);
    funct = FUNCT_MFLO; #1;
    chk("t2_rd_lo", rd_data, 32'h0000_0001);
    funct = 6'b100000; #1;
    chk("t2_rd_other", rd_data, 0);

    // Start during RUN cycle 10 is ignored.
    @(negedge clk);
    run_mult(32'd3, 32'd5, 12, -1, cyc, muls);
    chk("t3_latency", cyc - 1, 34);
    chk("t3_hi", hi, 0);
    chk("t3_lo", lo, 15);
    chk("t3_mul_a", mul_a, 3);
    chk("t3_mul_b", mul_b, 5);
    n_busy = 0;
    repeat (3) begin @(negedge clk); if (busy) n_busy++; end
    chk("t3_no_queue", n_busy, 0);

    // Reset at RUN cycle 20.
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 22, cyc, muls);
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_hi", hi, 0);
    chk("t4_lo", lo, 0);
    chk("t4_clr", mul_clr, 1);
    chk("t4_sig", mul_signal, SIG_NOP);
    chk("t4_mul_a", mul_a, 0);
    @(negedge clk);
    reset = 1'b1;
    n_done = 0; n_busy = 0;
    repeat (40) begin @(negedge clk); if (done) n_done++; if (busy) n_busy++; end
    chk("t4_no_done", n_done, 0);
    chk("t4_stays_idle", n_busy, 0);

    // ADD in IDLE is ignored.
    start = 1'b1; funct = 6'b100000; op_a = 32'd11; op_b = 32'd13;
    @(negedge clk);
    start = 1'b0;
    n_done = 0; n_busy = 0; n_sig = 0;
    if (busy) n_busy++;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) n_busy++;
      if (mul_signal != SIG_NOP) n_sig++;
    end
    chk("t5_busy", n_busy, 0);
    chk("t5_sig", n_sig, 0);
    chk("t5_done", n_done, 0);
    chk("t5_mul_a", mul_a, 0);

    // Back-to-back: second request issued in the done cycle of the first.
    run_mult(32'd2, 32'd3, -1, -1, cyc, muls);
    chk("t6a_done", done, 1);
    chk("t6a_lo", lo, 6);
    run_mult(32'd10, 32'd10, -1, -1, cyc, muls);
    chk("t6b_spacing", cyc, 35);
    chk("t6b_done", done, 1);
    chk("t6b_hi", hi, 0);
    chk("t6b_lo", lo, 100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
